// File: rtl/ecc_secded_check.sv
// Pipelined SECDED checker/corrector for SRAM read data: S1 recomputes the syndrome
// and overall parity, S2 corrects single data-bit errors, classifies and counts.
module ecc_secded_check #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16,
  localparam int HAM_W = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
  localparam int CHK_W = HAM_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [HAM_W-1:0]  out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CNT_W-1:0]  cnt_sec,
  output logic [CNT_W-1:0]  cnt_ded,
  input  logic              cnt_clr
);

  localparam int N_POS = DATA_W + HAM_W;
  localparam logic [HAM_W-1:0] MAX_POS = HAM_W'(N_POS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Data bits occupy the non-power-of-two codeword positions in ascending order.
  function automatic logic [DATA_W-1:0] ham_mask(input int bit_i);
    logic [DATA_W-1:0] m;
    int j;
    m = '0;
    j = 0;
    for (int q = 1; q <= N_POS; q++) begin
      if ((q & (q - 1)) != 0) begin
        m[j] = ((q >> bit_i) & 1) != 0;
        j++;
      end
    end
    return m;
  endfunction

  function automatic logic [HAM_W-1:0] data_pos(input int idx);
    logic [HAM_W-1:0] p;
    int j;
    p = '0;
    j = 0;
    for (int q = 1; q <= N_POS; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (j == idx) p = HAM_W'(q);
        j++;
      end
    end
    return p;
  endfunction

  logic              s1_valid_q, s1_pe_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [HAM_W-1:0]  s1_syn_q;
  logic              s2_valid_q, s2_sec_q, s2_ded_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [HAM_W-1:0]  s2_syn_q;
  logic [CNT_W-1:0]  cnt_sec_q, cnt_ded_q, cnt_sec_d, cnt_ded_d;

  logic [HAM_W-1:0]  syn_d;
  logic              pe_d;
  logic [DATA_W-1:0] flip;
  logic [DATA_W-1:0] s2_data_d;
  logic              s2_sec_d, s2_ded_d, syn_in_range;
  logic              s1_adv, s2_adv, deliver;

  // Handshake: a word moves on a cycle where valid && ready are both high at the
  // rising edge; a stage loads whenever it is empty or the stage after it drains.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign deliver  = s2_valid_q && out_ready;

  for (genvar i = 0; i < HAM_W; i++) begin : g_syn
    localparam logic [DATA_W-1:0] MASK = ham_mask(i);
    assign syn_d[i] = in_code[i] ^ (^(in_data & MASK));
  end
  assign pe_d = (^in_data) ^ (^in_code);

  for (genvar j = 0; j < DATA_W; j++) begin : g_flip
    localparam logic [HAM_W-1:0] POS = data_pos(j);
    assign flip[j] = s1_pe_q && (s1_syn_q == POS);
  end

  // With odd parity any in-range syndrome (including 0 and powers of two) is one error.
  assign syn_in_range = (s1_syn_q <= MAX_POS);
  assign s2_data_d    = s1_data_q ^ flip;
  assign s2_sec_d     = s1_pe_q && syn_in_range;
  assign s2_ded_d     = (s1_pe_q && !syn_in_range) || (!s1_pe_q && (s1_syn_q != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pe_q    <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_syn_q  <= syn_d;
        s1_pe_q   <= pe_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_syn_q  <= s1_syn_q;
        s2_sec_q  <= s2_sec_d;
        s2_ded_q  <= s2_ded_d;
      end
    end
  end

  always_comb begin
    cnt_sec_d = cnt_sec_q;
    cnt_ded_d = cnt_ded_q;
    if (cnt_clr) begin
      cnt_sec_d = '0;
      cnt_ded_d = '0;
    end else if (deliver) begin
      if (s2_sec_q && (cnt_sec_q != CNT_MAX)) cnt_sec_d = cnt_sec_q + 1'b1;
      if (s2_ded_q && (cnt_ded_q != CNT_MAX)) cnt_ded_d = cnt_ded_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_sec_q <= '0;
      cnt_ded_q <= '0;
    end else begin
      cnt_sec_q <= cnt_sec_d;
      cnt_ded_q <= cnt_ded_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_sec      = s2_sec_q;
  assign out_ded      = s2_ded_q;
  assign cnt_sec      = cnt_sec_q;
  assign cnt_ded      = cnt_ded_q;

endmodule

// File: doc/ecc_secded_check.md
# ecc_secded_check

Parametrised, pipelined SECDED checker/corrector; the read-side partner of the team's packet-buffer ECC encoders. Takes a data word plus its stored check bits, recomputes the Hamming syndrome and overall parity, and corrects single-bit errors. It flags double-bit errors and keeps saturating error counters. Sits between SRAM read data and the dequeue datapath with a valid/ready stream on both sides.

## Interface

Parameters:
- DATA_W, 128, data word width (≥ 4).
- CNT_W, 16, width of each error counter.
- HAM_W (localparam), smallest r with 2^r ≥ DATA_W + r + 1; 8 for DATA_W=128.
- CHK_W (localparam), HAM_W + 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  DATA_W  stored data word.
- in_code  in  CHK_W  stored check bits: [HAM_W-1:0] Hamming bits, [HAM_W] overall parity.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  corrected data word.
- out_syndrome  out  HAM_W  raw syndrome of this word.
- out_sec  out  1  single error detected (corrected, or located in a check bit).
- out_ded  out  1  uncorrectable error; data passed unmodified.
- cnt_sec  out  CNT_W  count of delivered words with out_sec.
- cnt_ded  out  CNT_W  count of delivered words with out_ded.
- cnt_clr  in  1  synchronous clear of both counters.

## Operation

- Code layout: codeword positions 1..DATA_W+HAM_W. Powers of two hold Hamming bits; data bits fill the remaining positions in ascending order (data[0]→3, data[1]→5, data[2]→6, data[3]→7, data[4]→9 …; for 128 bits, data[127]→136).
- Hamming bit i = XOR of data bits whose position has bit i set. Overall parity = XOR of all data bits and all Hamming bits.
- syndrome[i] = in_code[i] XOR recomputed Hamming bit i. pe = XOR of all in_data and all in_code bits.
- Classification:
  - syn=0, pe=0: clean.
  - syn=0, pe=1: overall-parity-bit error. sec=1, data unchanged.
  - syn≠0, pe=1, syn a power of two: Hamming-bit error. sec=1, data unchanged.
  - syn≠0, pe=1, syn is a valid data position: flip that data bit. sec=1.
  - syn≠0, pe=1, syn > DATA_W+HAM_W: ded=1, data unchanged.
  - syn≠0, pe=0: ded=1, data unchanged.
- sec and ded are never both 1.
- Counters update only on delivery (out_valid && out_ready). Each increments by 1 on its flag and saturates at 2^CNT_W−1. When cnt_clr is high, the counter becomes 0 that cycle; cnt_clr has priority over a simultaneous increment.

## Timing

- Two register stages:
  - S1 registers data, syndrome and pe.
  - S2 registers corrected data and flags; S2 drives the out_* ports.
- Latency from input handshake to out_valid is 2 cycles with no backpressure. Throughput is 1 word/cycle.
- Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. The ready path is combinational; no bubble is needed under continuous flow.
- While out_valid && !out_ready, all out_* ports hold stable. No word is dropped or duplicated.
- Reset values: out_valid=0, out_data=0, out_syndrome=0, out_sec=0, out_ded=0, cnt_sec=0, cnt_ded=0, internal valids=0. in_ready=1 in the cycle after rst deasserts.
- Reset asserted mid-stream discards all in-flight words; no partial output is delivered.
- Inputs are sampled only on an input handshake; in_data and in_code are don't-care otherwise.

## Test plan

- Clean stream: 1000 back-to-back random words with correct check bits, out_ready=1 → each word out 2 cycles later, identical data, syndrome=0, sec=ded=0, counters stay 0.
- Single data error: DATA_W=128, data=0, code=0, data[0] flipped → out_data=0, out_syndrome=8'h03, sec=1. data[127] flipped → syndrome 8'h88, corrected to 0, cnt_sec=2.
- Check-bit errors: code[8] flipped → syndrome 0, sec=1. code[3] flipped → syndrome 8'h08, sec=1, data unchanged.
- Double error: data[0] and data[1] flipped → syndrome 8'h06, ded=1, out_data=128'h3 unchanged, cnt_ded=1.
- Backpressure: random out_ready (50%) over a 500-word stream → output sequence equals input sequence in order, outputs stable while stalled, no loss.
- Counters and reset: CNT_W=4, 20 single-error words → cnt_sec=15 (saturated). cnt_clr coincident with a sec delivery → cnt_sec=0. rst with 2 words in flight → out_valid=0 next cycle, words never appear.
